// File: rtl/byte_frame_parser_pkg.sv
// Shared types and constants for the byte frame parser.
// ST_CSUM exists only when FRAME_CHECKSUM_EN is defined.
package byte_frame_parser_pkg;

    localparam int         BYTE_W  = 8;
    localparam logic [7:0] SYNC_B0 = 8'hA5;
    localparam logic [7:0] SYNC_B1 = 8'h5A;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_SYNC2,
        ST_LEN,
`ifdef FRAME_CHECKSUM_EN
        ST_PAYLOAD,
        ST_CSUM
`else
        ST_PAYLOAD
`endif
    } state_t;

endpackage

// File: rtl/byte_frame_parser_frame_csum.sv
// Running modulo-256 frame checksum over the LEN and payload bytes.
// Compiled only when FRAME_CHECKSUM_EN is defined.
`ifdef FRAME_CHECKSUM_EN
module frame_csum
    import byte_frame_parser_pkg::*;
(
    input  logic              clk_100M,
    input  logic              rst,
    input  logic              clear,
    input  logic              accum,
    input  logic [BYTE_W-1:0] data_in,
    output logic              match
);

    logic [BYTE_W-1:0] sum;

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (accum) begin
            sum <= sum + data_in;
        end
    end

    assign match = (sum == data_in);

endmodule
`endif

// File: rtl/byte_frame_parser.sv
// Sync-word hunter and payload extractor for the delayed byte stream.
// Optional trailing checksum byte is enabled by defining FRAME_CHECKSUM_EN.
module byte_frame_parser
    import byte_frame_parser_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              data_vld,
    output logic [BYTE_W-1:0] pl_data,
    output logic              pl_vld,
    output logic              pl_first,
    output logic              pl_last,
    output logic [BYTE_W-1:0] frm_len,
    output logic              frm_done,
    output logic              frm_err,
    output logic              busy
);

    localparam int                GAP_W     = $clog2(TIMEOUT + 1);
    localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);

    state_t            state, state_nx;
    logic [GAP_W-1:0]  gap_cnt, gap_nx;
    logic [BYTE_W-1:0] rem_cnt, rem_nx;
    logic              first_pend, first_nx;
    logic [BYTE_W-1:0] pl_data_nx, frm_len_nx;
    logic              pl_vld_nx, pl_first_nx, pl_last_nx;
    logic              frm_done_nx, frm_err_nx, busy_nx;
    logic              timed_out;

`ifdef FRAME_CHECKSUM_EN
    logic csum_match;

    frame_csum u_csum (
        .clk_100M (clk_100M),
        .rst      (rst),
        .clear    (state == ST_SYNC2 && data_vld && data_in == SYNC_B1),
        .accum    (data_vld && (state == ST_LEN || state == ST_PAYLOAD)),
        .data_in  (data_in),
        .match    (csum_match)
    );
`endif

    assign timed_out = (gap_cnt == GAP_W'(TIMEOUT));

    always_comb begin
        state_nx    = state;
        rem_nx      = rem_cnt;
        first_nx    = first_pend;
        gap_nx      = '0;
        pl_data_nx  = pl_data;
        pl_vld_nx   = 1'b0;
        pl_first_nx = 1'b0;
        pl_last_nx  = 1'b0;
        frm_len_nx  = frm_len;
        frm_done_nx = 1'b0;
        frm_err_nx  = 1'b0;

        case (state)
            ST_HUNT: begin
                if (data_vld && data_in == SYNC_B0) state_nx = ST_SYNC2;
            end
            ST_SYNC2: begin
                if (data_vld) begin
                    if (data_in == SYNC_B1)      state_nx = ST_LEN;
                    else if (data_in != SYNC_B0) state_nx = ST_HUNT;
                end
            end
            ST_LEN: begin
                if (data_vld) begin
                    frm_len_nx = data_in;
                    rem_nx     = data_in;
                    if (data_in > MAX_LEN_B) begin
                        frm_err_nx = 1'b1;
                        state_nx   = ST_HUNT;
                    end else if (data_in == '0) begin
`ifdef FRAME_CHECKSUM_EN
                        state_nx    = ST_CSUM;
`else
                        frm_done_nx = 1'b1;
                        state_nx    = ST_HUNT;
`endif
                    end else begin
                        first_nx = 1'b1;
                        state_nx = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (data_vld) begin
                    pl_data_nx  = data_in;
                    pl_vld_nx   = 1'b1;
                    pl_first_nx = first_pend;
                    first_nx    = 1'b0;
                    rem_nx      = rem_cnt - 1'b1;
                    if (rem_cnt == BYTE_W'(1)) begin
                        pl_last_nx  = 1'b1;
`ifdef FRAME_CHECKSUM_EN
                        state_nx    = ST_CSUM;
`else
                        frm_done_nx = 1'b1;
                        state_nx    = ST_HUNT;
`endif
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CSUM: begin
                if (data_vld) begin
                    frm_done_nx = csum_match;
                    frm_err_nx  = !csum_match;
                    state_nx    = ST_HUNT;
                end
            end
`endif
            default: state_nx = ST_HUNT;
        endcase

        // Gap counter runs only inside a frame; a strobed byte always beats the timeout.
        if (state != ST_HUNT && !data_vld) begin
            if (timed_out) begin
                frm_err_nx = 1'b1;
                state_nx   = ST_HUNT;
            end else begin
                gap_nx = gap_cnt + GAP_W'(1);
            end
        end

        busy_nx = (state_nx != ST_HUNT);
    end

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state      <= ST_HUNT;
            gap_cnt    <= '0;
            rem_cnt    <= '0;
            first_pend <= 1'b0;
            pl_data    <= '0;
            pl_vld     <= 1'b0;
            pl_first   <= 1'b0;
            pl_last    <= 1'b0;
            frm_len    <= '0;
            frm_done   <= 1'b0;
            frm_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            gap_cnt    <= gap_nx;
            rem_cnt    <= rem_nx;
            first_pend <= first_nx;
            pl_data    <= pl_data_nx;
            pl_vld     <= pl_vld_nx;
            pl_first   <= pl_first_nx;
            pl_last    <= pl_last_nx;
            frm_len    <= frm_len_nx;
            frm_done   <= frm_done_nx;
            frm_err    <= frm_err_nx;
            busy       <= busy_nx;
        end
    end

endmodule

// File: tb/tb_byte_frame_parser.sv
// Scoreboard bench for byte_frame_parser; follows FRAME_CHECKSUM_EN if defined.
module tb_byte_frame_parser;

    localparam int TIMEOUT = 1000;

    logic       clk_100M = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_vld = 1'b0;
    logic [7:0] pl_data, frm_len;
    logic       pl_vld, pl_first, pl_last, frm_done, frm_err, busy;

    byte_frame_parser #(.MAX_LEN(64), .TIMEOUT(TIMEOUT)) dut (
        .clk_100M (clk_100M),
        .rst      (rst),
        .data_in  (data_in),
        .data_vld (data_vld),
        .pl_data  (pl_data),
        .pl_vld   (pl_vld),
        .pl_first (pl_first),
        .pl_last  (pl_last),
        .frm_len  (frm_len),
        .frm_done (frm_done),
        .frm_err  (frm_err),
        .busy     (busy)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct {
        logic [7:0] data;
        logic       first;
        logic       last;
        int         stamp;
    } pl_exp_t;

    typedef struct {
        logic [1:0] kind;   // {err, done}
        int         stamp;
    } ev_exp_t;

    pl_exp_t    plq[$];
    ev_exp_t    evq[$];
    int         cyc = 0;
    int         last_stamp = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] pbuf [0:63];

    always @(posedge clk_100M) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk_100M);
        data_in    = b;
        data_vld   = 1'b1;
        last_stamp = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_100M);
            data_vld = 1'b0;
            data_in  = 8'h00;
        end
    endtask

    task automatic send_pl(input logic [7:0] b, input logic first, input logic last);
        pl_exp_t e;
        send(b);
        e.data = b; e.first = first; e.last = last; e.stamp = last_stamp;
        plq.push_back(e);
    endtask

    task automatic push_ev(input logic [1:0] kind, input int stamp);
        ev_exp_t e;
        e.kind = kind; e.stamp = stamp;
        evq.push_back(e);
    endtask

    // Full frame from sync word on; bad_csum corrupts the trailing checksum byte.
    task automatic do_frame(input int len, input bit bad_csum);
        logic [7:0] sum;
        send(8'hA5);
        send(8'h5A);
        send(8'(len));
        sum = 8'(len);
        for (int i = 0; i < len; i++) begin
            send_pl(pbuf[i], i == 0, i == len - 1);
            sum = sum + pbuf[i];
        end
`ifdef FRAME_CHECKSUM_EN
        send(bad_csum ? ~sum : sum);
        push_ev(bad_csum ? 2'b10 : 2'b01, last_stamp);
`else
        push_ev(2'b01, last_stamp);
`endif
    endtask

    always @(negedge clk_100M) begin
        if (!rst) begin
            while (plq.size() > 0 && plq[0].stamp < cyc) begin
                chk("pl_missing", 32'd0, 32'd1);
                void'(plq.pop_front());
            end
            while (evq.size() > 0 && evq[0].stamp < cyc) begin
                chk("ev_missing", 32'd0, 32'd1);
                void'(evq.pop_front());
            end
            if (pl_vld) begin
                if (plq.size() == 0) begin
                    chk("pl_unexpected", 32'd1, 32'd0);
                end else begin
                    pl_exp_t e;
                    e = plq.pop_front();
                    chk("pl_data", 32'(pl_data), 32'(e.data));
                    chk("pl_first", 32'(pl_first), 32'(e.first));
                    chk("pl_last", 32'(pl_last), 32'(e.last));
                    chk("pl_cycle", 32'(cyc), 32'(e.stamp));
`ifndef FRAME_CHECKSUM_EN
                    chk("done_with_last", 32'(frm_done), 32'(e.last));
`endif
                end
            end
            if (frm_done || frm_err) begin
                if (evq.size() == 0) begin
                    chk("ev_unexpected", 32'({frm_err, frm_done}), 32'd0);
                end else begin
                    ev_exp_t e;
                    e = evq.pop_front();
                    chk("ev_kind", 32'({frm_err, frm_done}), 32'(e.kind));
                    chk("ev_cycle", 32'(cyc), 32'(e.stamp));
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk_100M);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pl_vld", 32'(pl_vld), 32'd0);
        chk("rst_pl_data", 32'(pl_data), 32'd0);
        chk("rst_frm_len", 32'(frm_len), 32'd0);
        chk("rst_pulses", 32'({frm_done, frm_err, pl_first, pl_last}), 32'd0);
        rst = 1'b0;
        idle(2);

        // Leading junk byte then a 3-byte frame.
        send(8'h00);
        pbuf[0] = 8'h11; pbuf[1] = 8'h22; pbuf[2] = 8'h33;
        do_frame(3, 1'b0);
        idle(2);
        chk("frm_len_3", 32'(frm_len), 32'd3);
        chk("busy_idle", 32'(busy), 32'd0);

        // Repeated A5 before 5A, single byte payload, then back-to-back frame.
        send(8'hA5);
        pbuf[0] = 8'h7F;
        do_frame(1, 1'b0);
        pbuf[0] = 8'hC3; pbuf[1] = 8'h3C;
        do_frame(2, 1'b0);
        idle(2);

        // Oversize length.
        send(8'hA5); send(8'h5A); send(8'h41);
        push_ev(2'b10, last_stamp);
        idle(3);
        chk("busy_after_len_err", 32'(busy), 32'd0);
        chk("frm_len_41", 32'(frm_len), 32'h41);

        // Zero length and maximum length.
        do_frame(0, 1'b0);
        for (int i = 0; i < 64; i++) pbuf[i] = 8'(i * 7 + 1);
        do_frame(64, 1'b0);
        idle(2);
        chk("frm_len_64", 32'(frm_len), 32'd64);

`ifdef FRAME_CHECKSUM_EN
        // Wrong checksum: 02 01 02 then 00 (expected 05).
        send(8'hA5); send(8'h5A); send(8'h02);
        send_pl(8'h01, 1'b1, 1'b0);
        send_pl(8'h02, 1'b0, 1'b1);
        send(8'h00);
        push_ev(2'b10, last_stamp);
        idle(2);
        pbuf[0] = 8'hFF; pbuf[1] = 8'h01;
        do_frame(2, 1'b1);
        idle(2);
`endif

        // Gap of exactly TIMEOUT idle cycles: the next byte still wins.
        send(8'hA5); send(8'h5A); send(8'h02);
        send_pl(8'h44, 1'b1, 1'b0);
        idle(TIMEOUT);
        send_pl(8'h55, 1'b0, 1'b1);
`ifdef FRAME_CHECKSUM_EN
        send(8'h02 + 8'h44 + 8'h55);
`endif
        push_ev(2'b01, last_stamp);
        idle(2);

        // Real timeout after 2nd payload byte of a length-4 frame.
        send(8'hA5); send(8'h5A); send(8'h04);
        send_pl(8'hAA, 1'b1, 1'b0);
        send_pl(8'hBB, 1'b0, 1'b0);
        push_ev(2'b10, last_stamp + TIMEOUT + 1);
        idle(TIMEOUT + 5);
        chk("busy_after_timeout", 32'(busy), 32'd0);
        pbuf[0] = 8'h01; pbuf[1] = 8'h02; pbuf[2] = 8'h03;
        do_frame(3, 1'b0);
        idle(2);

        // Asynchronous reset in mid-payload.
        send(8'hA5); send(8'h5A); send(8'h05);
        send_pl(8'h10, 1'b1, 1'b0);
        send_pl(8'h20, 1'b0, 1'b0);
        idle(1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pl_data", 32'(pl_data), 32'd0);
        chk("midrst_frm_len", 32'(frm_len), 32'd0);
        chk("midrst_pulses", 32'({pl_vld, frm_done, frm_err}), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(3);
        pbuf[0] = 8'h5A; pbuf[1] = 8'hA5;
        do_frame(2, 1'b0);
        idle(4);

        chk("plq_empty", 32'(plq.size()), 32'd0);
        chk("evq_empty", 32'(evq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/byte_frame_parser.md
# byte_frame_parser

Framing stage directly downstream of the 8-bit byte delay line on `clk_100M`. It takes the delayed byte stream plus a byte strobe, hunts for the two-byte sync word 0xA5 0x5A, then reads a length byte and that many payload bytes, and forwards only the payload with first/last markers. It reports frame completion and errors to the control logic.

## Interface
- `MAX_LEN`, 64: largest accepted payload length; larger lengths are errors.
- `TIMEOUT`, 1000: maximum idle cycles between consecutive strobed bytes inside a frame.
- `clk_100M` input 1: system clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `data_in` input 8: byte from the upstream delay line.
- `data_vld` input 1: `data_in` is a valid new byte this cycle.
- `pl_data` output 8: payload byte.
- `pl_vld` output 1: `pl_data` valid, one-cycle pulse per payload byte.
- `pl_first` output 1: qualifies the first payload byte of a frame.
- `pl_last` output 1: qualifies the last payload byte of a frame.
- `frm_len` output 8: length of the current or last frame, held until the next LEN byte.
- `frm_done` output 1: one-cycle pulse when a frame completes without error.
- `frm_err` output 1: one-cycle pulse on a length, timeout or checksum error.
- `busy` output 1: high in every state except HUNT.

## Operation
- States: HUNT, SYNC2, LEN, PAYLOAD, CSUM.
- HUNT: byte 0xA5 moves to SYNC2; any other byte stays in HUNT.
- SYNC2:
  - 0x5A moves to LEN.
  - 0xA5 stays in SYNC2.
  - Any other byte returns to HUNT.
- LEN:
  - Latch the byte into `frm_len` and load the remaining-byte counter.
  - Length greater than `MAX_LEN`: pulse `frm_err`, return to HUNT.
  - Length 0: go to CSUM if `FRAME_CHECKSUM_EN` is defined; otherwise pulse `frm_done` and return to HUNT.
  - Otherwise go to PAYLOAD.
- PAYLOAD:
  - Each strobed byte is forwarded on `pl_data`/`pl_vld` and the counter decrements.
  - `pl_first` is set on the first forwarded byte, `pl_last` when the counter reaches 1.
  - After the last byte: go to CSUM if the checksum is compiled in; otherwise pulse `frm_done` and return to HUNT.
- CSUM: compare the received byte with the running sum, then pulse `frm_done` or `frm_err` and return to HUNT.
- Bytes are consumed only when `data_vld` is high; `data_in` is ignored otherwise.
- Timeout:
  - In SYNC2, LEN, PAYLOAD and CSUM, a gap counter increments on every cycle without `data_vld` and clears on `data_vld`.
  - When the gap counter reaches `TIMEOUT`: pulse `frm_err`, return to HUNT.
  - No partial-frame flush; payload bytes already forwarded stand, and `pl_last` is never issued for an aborted frame.
- No backpressure: the block never stalls upstream.

## Timing
- Every output is registered; `pl_vld` and the payload markers appear one cycle after the `data_vld` cycle that carried the byte.
- `frm_done`/`frm_err` assert one cycle after the terminating byte.
  - Without the checksum, `frm_done` coincides with `pl_last`.
  - For a timeout, they assert one cycle after the count reaches `TIMEOUT`.
- A 0xA5 can be accepted in HUNT in the cycle right after a `frm_done`/`frm_err` pulse, so back-to-back frames lose no bytes.
- Reset values: state HUNT; all pulses 0; `pl_data` 0x00; `frm_len` 0x00; `busy` 0; counters and checksum 0.
- `rst` asserted mid-frame aborts the frame immediately with no `frm_err` pulse.
- A timeout and a strobed byte in the same cycle: the byte wins and the gap counter clears.

## Configuration
- Macro `FRAME_CHECKSUM_EN`.
- Defined:
  - CSUM state present; a checksum byte follows the payload.
  - Expected value = (LEN + sum of payload bytes) mod 256.
  - Mismatch pulses `frm_err`; match pulses `frm_done`.
- Undefined: no CSUM state, no accumulator; the frame ends at the last payload byte (or at LEN when the length is 0).

## Structure
- Shared package: state encoding type, constants `SYNC_B0` = 0xA5 and `SYNC_B1` = 0x5A, byte width 8.
- Sub-module `frame_csum`, instantiated only under `FRAME_CHECKSUM_EN`:
  - 8-bit accumulator, cleared in SYNC2 on the 0x5A byte.
  - Accumulates on LEN and PAYLOAD bytes; compare output is used in CSUM.
- Gap-counter width: $clog2(`TIMEOUT`+1).

## Test plan
- Stream 0x00 0xA5 0x5A 0x03 0x11 0x22 0x33 (+0x69 when checksum enabled) -> `pl_vld` ×3 with 0x11 (first), 0x22, 0x33 (last); `frm_done` ×1; `frm_len` = 3.
- 0xA5 0xA5 0x5A 0x01 0x7F (+0x80) -> sync still found; one payload 0x7F with both `pl_first` and `pl_last` set.
- Length byte 0x41 with `MAX_LEN` = 64 -> `frm_err` one cycle later, no `pl_vld`, `busy` drops.
- Checksum enabled, frame 0xA5 0x5A 0x02 0x01 0x02 followed by checksum 0x00 (expected 0x05) -> `frm_err`, no `frm_done`.
- Stop strobing for `TIMEOUT` cycles after the 2nd payload byte of a length-4 frame -> `frm_err`, state HUNT; a following valid frame parses normally.
- Assert `rst` mid-payload -> all outputs at reset values immediately, no `frm_err`; the next frame parses correctly.
